casilla_commit: RTL and testbench
=================================

Name: casilla_commit

Overview:
- Consumer end of the cell-selection interface.
- Accepts a 1-based 5x5 board cell index plus a level "selected" flag from the cursor/selector block.
- Validates each new selection, commits it into a 25-cell ownership board for the player whose turn it is, then toggles the turn.
- Reports accept/reject pulses and exposes a read port for the display/game-logic side.

Parameters:
- NCELLS, 25, number of board cells; valid indices 1..NCELLS.
- IDXW, 5, index width in bits.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-low.
- enable  in  1  game-active qualifier; when low, new selections are not captured.
- clear  in  1  synchronous board clear, active-high.
- cell_idx  in  IDXW  selected cell index from the selector, 1-based.
- is_selected  in  1  level flag from the selector; a new selection is its 0->1 transition.
- ack  out  1  one-cycle pulse: selection committed.
- nack  out  1  one-cycle pulse: selection rejected.
- busy  out  1  high while the FSM is not in IDLE.
- turn  out  1  current player, 0 or 1.
- occ  out  NCELLS  bit i = cell i+1 occupied.
- owner  out  NCELLS  bit i = player owning cell i+1; 0 when unoccupied.
- moves  out  IDXW  number of committed cells.
- board_full  out  1  moves == NCELLS.
- rd_idx  in  IDXW  read address, 1-based.
- rd_cell  out  2  combinational read: 00 empty, 10 player 0, 11 player 1; 00 for rd_idx of 0 or >NCELLS.

Behaviour:
- All state updates on posedge clk.
- rst=0 has priority over everything else and sets:
  - state=IDLE, sel_prev=0, ack=0, nack=0, turn=0
  - occ=0, owner=0, moves=0, latched index=0
- clear=1 (with rst=1) has the same effect as reset, except sel_prev keeps tracking is_selected.
- Edge detect:
  - sel_prev <= is_selected every cycle, regardless of enable or state.
  - sel_rise = is_selected & ~sel_prev.
- FSM states are IDLE, CHECK, COMMIT, REJECT.
- IDLE:
  - If sel_rise & enable: latch cell_idx into idx_q, then go to CHECK.
  - Otherwise stay in IDLE.
- CHECK (one cycle):
  - If idx_q == 0, idx_q > NCELLS, or occ[idx_q-1]=1: go to REJECT.
  - Otherwise: go to COMMIT.
- COMMIT (one cycle), registered updates:
  - occ[idx_q-1] <= 1
  - owner[idx_q-1] <= turn
  - turn <= ~turn
  - moves <= moves+1
  - ack <= 1
  - next state IDLE
- REJECT (one cycle):
  - nack <= 1; next state IDLE.
  - turn, board and moves are unchanged.
- ack and nack are registered and high for exactly one cycle. They are never high together.
- Latency:
  - If sel_rise is sampled at edge k, the verdict is made at edge k+1.
  - ack/nack and the board update become visible after edge k+2.
  - is_selected may stay high indefinitely without re-triggering.
- busy = (state != IDLE). sel_rise while busy is ignored, and no event is queued for it.
- enable low in IDLE: sel_rise is discarded. A selection already in flight completes regardless of enable.
- board_full:
  - Any later selection is rejected, because the cell is occupied.
  - moves saturates at NCELLS and never wraps.
- A clear or rst issued mid-operation aborts the operation. No ack/nack is produced for it.
- The read port is purely combinational from occ/owner. It reflects a commit in the same cycle ack is high.

Test Plan:
- Reset: rst=0 for 2 cycles, then rst=1 -> occ=0, owner=0, turn=0, moves=0, ack=nack=busy=0; rd_cell=00 for every rd_idx.
- Basic commit: enable=1, cell_idx=7, raise is_selected at edge k -> ack=1 only after edge k+2; occ[6]=1, owner[6]=0, turn=1, moves=1; rd_idx=7 gives rd_cell=10.
- Duplicate and hold:
  - Keep is_selected high for 10 cycles -> no further ack.
  - Drop it, then raise it again with cell_idx=7 -> nack after edge k+2; turn stays 1, moves stays 1.
- Out-of-range indices: cell_idx=0, then cell_idx=26 -> nack each time; board unchanged. An enable=0 rise -> neither ack nor nack.
- Fill board: commit cells 1..25 in order -> owner alternates 0/1 (owner=0x0AAAAAA pattern, odd-indexed bits 1); moves=25, board_full=1; a further selection -> nack, moves stays 25.
- Abort and busy:
  - clear=1 during CHECK -> no ack/nack; board zero; turn=0.
  - Second sel_rise while busy=1 -> ignored; exactly one ack produced.

Source files
------------

// File: rtl/casilla_commit.sv
// casilla_commit
// Consumer end of the cell-selection interface. Each new selection from the
// cursor/selector block (the 0->1 edge of is_selected) is latched, checked
// against the 5x5 board and either committed for the current player or
// rejected. After a commit the turn toggles.
//
// Ports
//   clk          system clock
//   rst          synchronous reset, active-low
//   enable       game-active qualifier for capturing new selections
//   clear        synchronous board clear, active-high
//   cell_idx     selected cell, 1-based
//   is_selected  level flag from the selector
//   ack / nack   one-cycle commit / reject pulses (registered)
//   busy         high while a selection is in flight
//   turn         player whose move is next
//   occ / owner  per-cell occupied flag and owning player (bit i = cell i+1)
//   moves        committed cell count, saturating at NCELLS
//   board_full   every cell committed
//   rd_idx       1-based read address
//   rd_cell      00 empty / out of range, 10 player 0, 11 player 1
//
// state  | meaning
// IDLE   | waiting for a qualified rising edge of is_selected
// CHECK  | latched index being validated against range and occupancy
// COMMIT | writing the cell for the current player, pulsing ack
// REJECT | pulsing nack, board untouched

module casilla_commit #(
    parameter int NCELLS = 25,
    parameter int IDXW   = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              clear,
    input  logic [IDXW-1:0]   cell_idx,
    input  logic              is_selected,
    output logic              ack,
    output logic              nack,
    output logic              busy,
    output logic              turn,
    output logic [NCELLS-1:0] occ,
    output logic [NCELLS-1:0] owner,
    output logic [IDXW-1:0]   moves,
    output logic              board_full,
    input  logic [IDXW-1:0]   rd_idx,
    output logic [1:0]        rd_cell
);

    localparam logic [IDXW-1:0] NC = IDXW'(NCELLS);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CHECK  = 2'd1,
        COMMIT = 2'd2,
        REJECT = 2'd3
    } state_t;

    state_t            state;
    logic              sel_prev;
    logic [IDXW-1:0]   idx_q;
    logic              sel_rise;
    logic              idx_valid;
    logic [NCELLS-1:0] cell_mask;
    logic              cell_taken;
    logic              rd_valid;
    logic [NCELLS-1:0] rd_mask;

    assign sel_rise = is_selected & ~sel_prev;

    // One-hot mask of the latched cell; all-zero for an out-of-range index so
    // the occupancy test and the board write never index outside the vector.
    assign idx_valid  = (idx_q != '0) && (idx_q <= NC);
    assign cell_mask  = idx_valid ? (NCELLS'(1) << (idx_q - 1'b1)) : '0;
    assign cell_taken = |(occ & cell_mask);

    assign rd_valid = (rd_idx != '0) && (rd_idx <= NC);
    assign rd_mask  = rd_valid ? (NCELLS'(1) << (rd_idx - 1'b1)) : '0;
    assign rd_cell  = (|(occ & rd_mask)) ? {1'b1, |(owner & rd_mask)} : 2'b00;

    assign busy       = (state != IDLE);
    assign board_full = (moves == NC);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            sel_prev <= 1'b0;
            idx_q    <= '0;
            ack      <= 1'b0;
            nack     <= 1'b0;
            turn     <= 1'b0;
            occ      <= '0;
            owner    <= '0;
            moves    <= '0;
        end else begin
            // Edge detector keeps tracking through clear so a level held
            // across a clear does not look like a fresh selection.
            sel_prev <= is_selected;
            if (clear) begin
                state <= IDLE;
                idx_q <= '0;
                ack   <= 1'b0;
                nack  <= 1'b0;
                turn  <= 1'b0;
                occ   <= '0;
                owner <= '0;
                moves <= '0;
            end else begin
                ack  <= 1'b0;
                nack <= 1'b0;
                case (state)
                    IDLE: begin
                        if (sel_rise && enable) begin
                            idx_q <= cell_idx;
                            state <= CHECK;
                        end
                    end
                    CHECK: begin
                        if (!idx_valid || cell_taken) state <= REJECT;
                        else                          state <= COMMIT;
                    end
                    COMMIT: begin
                        occ <= occ | cell_mask;
                        if (turn) owner <= owner | cell_mask;
                        turn <= ~turn;
                        if (moves != NC) moves <= moves + 1'b1;
                        ack   <= 1'b1;
                        state <= IDLE;
                    end
                    REJECT: begin
                        nack  <= 1'b1;
                        state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_casilla_commit.sv
// Directed bench for casilla_commit: reset state, commit latency, hold and
// duplicate handling, range checks, enable gating, full-board behaviour,
// abort by clear and ignoring selections while busy.

module tb_casilla_commit;

    logic        clk;
    logic        rst;
    logic        enable;
    logic        clear;
    logic [4:0]  cell_idx;
    logic        is_selected;
    logic        ack;
    logic        nack;
    logic        busy;
    logic        turn;
    logic [24:0] occ;
    logic [24:0] owner;
    logic [4:0]  moves;
    logic        board_full;
    logic [4:0]  rd_idx;
    logic [1:0]  rd_cell;

    int total;
    int bad;

    casilla_commit #(.NCELLS(25), .IDXW(5)) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .clear       (clear),
        .cell_idx    (cell_idx),
        .is_selected (is_selected),
        .ack         (ack),
        .nack        (nack),
        .busy        (busy),
        .turn        (turn),
        .occ         (occ),
        .owner       (owner),
        .moves       (moves),
        .board_full  (board_full),
        .rd_idx      (rd_idx),
        .rd_cell     (rd_cell)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Raise is_selected with idx, sample ack/nack after edge k+2, then drop it.
    task automatic do_sel(input logic [4:0] idx, output logic a, output logic n);
        cell_idx    = idx;
        is_selected = 1'b1;
        tick();
        tick();
        tick();
        a = ack;
        n = nack;
        is_selected = 1'b0;
        tick();
    endtask

    logic a, n;
    int   cnt;

    initial begin
        total = 0;
        bad   = 0;
        rst = 1'b0; enable = 1'b1; clear = 1'b0;
        cell_idx = '0; is_selected = 1'b0; rd_idx = '0;

        // Reset
        tick(); tick();
        rst = 1'b1;
        tick();
        chk("rst_occ",   32'(occ),   32'h0);
        chk("rst_owner", 32'(owner), 32'h0);
        chk("rst_turn",  32'(turn),  32'h0);
        chk("rst_moves", 32'(moves), 32'h0);
        chk("rst_ack",   32'(ack),   32'h0);
        chk("rst_nack",  32'(nack),  32'h0);
        chk("rst_busy",  32'(busy),  32'h0);
        cnt = 0;
        for (int i = 0; i < 32; i++) begin
            rd_idx = 5'(i);
            #1;
            if (rd_cell != 2'b00) cnt++;
        end
        chk("rst_rd_nonempty", 32'(cnt), 32'h0);
        tick();

        // Basic commit of cell 7 with latency check
        cell_idx = 5'd7; is_selected = 1'b1;
        tick();
        chk("basic_busy_k",  32'(busy), 32'h1);
        chk("basic_ack_k",   32'(ack),  32'h0);
        tick();
        chk("basic_ack_k1",  32'(ack),  32'h0);
        chk("basic_nack_k1", 32'(nack), 32'h0);
        tick();
        chk("basic_ack_k2",  32'(ack),   32'h1);
        chk("basic_nack_k2", 32'(nack),  32'h0);
        chk("basic_occ",     32'(occ),   32'h40);
        chk("basic_owner",   32'(owner), 32'h0);
        chk("basic_turn",    32'(turn),  32'h1);
        chk("basic_moves",   32'(moves), 32'h1);
        rd_idx = 5'd7; #1;
        chk("basic_rd7", 32'(rd_cell), 32'h2);

        // Hold is_selected high: no re-trigger
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (ack || nack) cnt++;
        end
        chk("hold_pulses", 32'(cnt),   32'h0);
        chk("hold_moves",  32'(moves), 32'h1);
        is_selected = 1'b0;
        tick();

        // Duplicate cell 7
        do_sel(5'd7, a, n);
        chk("dup_ack",   32'(a),     32'h0);
        chk("dup_nack",  32'(n),     32'h1);
        chk("dup_turn",  32'(turn),  32'h1);
        chk("dup_moves", 32'(moves), 32'h1);

        // Out-of-range indices
        do_sel(5'd0, a, n);
        chk("idx0_ack",  32'(a), 32'h0);
        chk("idx0_nack", 32'(n), 32'h1);
        do_sel(5'd26, a, n);
        chk("idx26_ack",  32'(a), 32'h0);
        chk("idx26_nack", 32'(n), 32'h1);
        chk("range_occ",   32'(occ),   32'h40);
        chk("range_moves", 32'(moves), 32'h1);
        chk("range_turn",  32'(turn),  32'h1);

        // Enable low: rise discarded
        enable = 1'b0;
        do_sel(5'd3, a, n);
        chk("en0_ack",  32'(a),   32'h0);
        chk("en0_nack", 32'(n),   32'h0);
        chk("en0_occ",  32'(occ), 32'h40);
        enable = 1'b1;

        // Clear, then fill the board in order
        clear = 1'b1; tick(); clear = 1'b0;
        chk("clr_occ",   32'(occ),   32'h0);
        chk("clr_turn",  32'(turn),  32'h0);
        chk("clr_moves", 32'(moves), 32'h0);
        cnt = 0;
        for (int i = 1; i <= 25; i++) begin
            do_sel(5'(i), a, n);
            if (a && !n) cnt++;
        end
        chk("fill_acks",  32'(cnt),        32'd25);
        chk("fill_occ",   32'(occ),        32'h1FFFFFF);
        chk("fill_owner", 32'(owner),      32'h0AAAAAA);
        chk("fill_moves", 32'(moves),      32'd25);
        chk("fill_full",  32'(board_full), 32'h1);
        chk("fill_turn",  32'(turn),       32'h1);
        rd_idx = 5'd2;  #1; chk("fill_rd2",  32'(rd_cell), 32'h3);
        rd_idx = 5'd25; #1; chk("fill_rd25", 32'(rd_cell), 32'h2);
        rd_idx = 5'd26; #1; chk("fill_rd26", 32'(rd_cell), 32'h0);
        do_sel(5'd5, a, n);
        chk("full_ack",   32'(a),     32'h0);
        chk("full_nack",  32'(n),     32'h1);
        chk("full_moves", 32'(moves), 32'd25);

        // Clear during CHECK aborts without a pulse
        clear = 1'b1; tick(); clear = 1'b0;
        cell_idx = 5'd4; is_selected = 1'b1;
        tick();
        chk("abort_busy_check", 32'(busy), 32'h1);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("abort_busy", 32'(busy), 32'h0);
        cnt = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (ack || nack) cnt++;
        end
        chk("abort_pulses", 32'(cnt),   32'h0);
        chk("abort_occ",    32'(occ),   32'h0);
        chk("abort_turn",   32'(turn),  32'h0);
        chk("abort_moves",  32'(moves), 32'h0);
        is_selected = 1'b0;
        tick();

        // Second rise while busy is ignored
        cell_idx = 5'd9; is_selected = 1'b1;
        tick();
        is_selected = 1'b0;
        tick();
        chk("busy2_busy", 32'(busy), 32'h1);
        cell_idx = 5'd10; is_selected = 1'b1;
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (ack) cnt++;
            if (nack) cnt = cnt + 100;
        end
        chk("busy2_acks",  32'(cnt),   32'h1);
        chk("busy2_occ",   32'(occ),   32'h100);
        chk("busy2_moves", 32'(moves), 32'h1);
        is_selected = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
